// File: rtl/weight_bank_dbuf.sv
// Double-buffered weight store: weights stream serially into a shadow bank,
// and a swap copies the whole shadow bank into the active bank that feeds the PEs.
module weight_bank_dbuf #(
   parameter  int WEIGHT_BW = 8,
   parameter  int NUM_PE    = 64,
   localparam int IDX_W     = $clog2(NUM_PE)
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        clr,
   input  logic                        w_valid,
   output logic                        w_ready,
   input  logic [WEIGHT_BW-1:0]        W,
   input  logic                        swap,
   output logic [NUM_PE*WEIGHT_BW-1:0] weight,
   output logic [IDX_W-1:0]            load_idx,
   output logic                        shadow_full,
   output logic                        swap_done
);

   typedef enum logic {ST_LOAD, ST_FULL} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] load_idx_reg;
   logic             swap_done_reg;
   logic             accept;
   logic             swap_fire;
   logic             idx_last;

   assign idx_last = (load_idx_reg == LAST_IDX);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_reg <= ST_LOAD;
      else       state_reg <= state_next;
   end

   // clr overrides both accept and swap in the same cycle
   always_comb begin
      state_next  = state_reg;
      w_ready     = 1'b0;
      shadow_full = 1'b0;
      accept      = 1'b0;
      swap_fire   = 1'b0;
      case (state_reg)
         ST_LOAD: begin
            w_ready = 1'b1;
            accept  = w_valid;
            if (w_valid && idx_last) state_next = ST_FULL;
         end
         ST_FULL: begin
            shadow_full = 1'b1;
            swap_fire   = swap;
            if (swap) state_next = ST_LOAD;
         end
         default: state_next = ST_LOAD;
      endcase
      if (clr) begin
         state_next = ST_LOAD;
         accept     = 1'b0;
         swap_fire  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         load_idx_reg  <= '0;
         swap_done_reg <= 1'b0;
      end else begin
         swap_done_reg <= swap_fire;
         if (clr)
            load_idx_reg <= '0;
         else if (accept)
            load_idx_reg <= idx_last ? '0 : load_idx_reg + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PE; gi++) begin : g_slot
         logic [WEIGHT_BW-1:0] shadow_reg;
         logic [WEIGHT_BW-1:0] active_reg;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               shadow_reg <= '0;
               active_reg <= '0;
            end else begin
               if (clr)
                  shadow_reg <= '0;
               else if (accept && (load_idx_reg == IDX_W'(gi)))
                  shadow_reg <= W;
               if (swap_fire)
                  active_reg <= shadow_reg;
            end
         end

         assign weight[gi*WEIGHT_BW +: WEIGHT_BW] = active_reg;
      end
   endgenerate

   assign load_idx  = load_idx_reg;
   assign swap_done = swap_done_reg;

endmodule
